// File: rtl/load_store_unit.sv
// Load/store initiator for a single-port word memory with one-cycle registered reads.
// Big-endian byte lanes; sub-word stores are done as read-modify-write.
//
// state | meaning
// IDLE  | waiting for req; latches op/addr/wdata and decodes on accept
// READ  | mem_read asserted for the addressed word
// DATA  | read word available; extract load result or merge sub-word store
// WRITE | mem_write asserted with full or merged word; done pulse follows
// FAULT | misaligned or illegal op; done+err pulse follows, no memory access
`timescale 1ns/1ps
module load_store_unit #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [3:0]            op,
    input  logic [ADDR_WIDTH+1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, FAULT} state_t;

    state_t                  state;
    logic [3:0]              op_q;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [31:0]             wr_word;
    logic                    req_ok;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [31:0]             load_val;
    logic [31:0]             merged;

    always_comb begin
        req_ok = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_SB: req_ok = 1'b1;
            OP_LH, OP_LHU, OP_SH: req_ok = ~addr[0];
            OP_LW, OP_SW:         req_ok = (addr[1:0] == 2'b00);
            default:              req_ok = 1'b0;
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_read_data[31:24];
            2'd1:    byte_sel = mem_read_data[23:16];
            2'd2:    byte_sel = mem_read_data[15:8];
            default: byte_sel = mem_read_data[7:0];
        endcase
        half_sel = addr_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];

        load_val = mem_read_data;
        case (op_q)
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            default: load_val = mem_read_data;
        endcase
    end

    // Replace only the addressed lane of the old word with the store data.
    always_comb begin
        merged = mem_read_data;
        if (op_q == OP_SB) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = wr_word[7:0];
                2'd1:    merged[23:16] = wr_word[7:0];
                2'd2:    merged[15:8]  = wr_word[7:0];
                default: merged[7:0]   = wr_word[7:0];
            endcase
        end else if (op_q == OP_SH) begin
            if (addr_q[1])
                merged[15:0] = wr_word[15:0];
            else
                merged[31:16] = wr_word[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= 4'h0;
            addr_q  <= '0;
            wr_word <= 32'h0;
            rdata   <= 32'h0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q    <= op;
                        addr_q  <= addr;
                        wr_word <= wdata;
                        if (!req_ok)
                            state <= FAULT;
                        else if (op == OP_SW)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: state <= DATA;
                DATA: begin
                    if (op_q[3]) begin
                        wr_word <= merged;
                        state   <= WRITE;
                    end else begin
                        rdata <= load_val;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                FAULT: begin
                    done  <= 1'b1;
                    err   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are gated by rst so a reset landing on WRITE never stores.
    assign mem_read       = (state == READ) && !rst;
    assign mem_write      = (state == WRITE) && !rst;
    assign busy           = (state != IDLE);
    assign mem_address    = addr_q[ADDR_WIDTH+1:2];
    assign mem_write_data = wr_word;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized back-to-back traffic
// against a byte-lane reference model of the memory and load results.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done, err, busy, mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_rdata;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .err(err), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Memory with one-cycle registered read; ld_* is a bench-only preload path.
    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (mem_write)
            mem[mem_address] <= mem_write_data;
        if (mem_read)
            mem_read_data <= mem[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 6'(a); ld_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Reference: lane position from size and byte offset, extension by op[2].
    task automatic model(input logic [3:0] o, input logic [7:0] a, input logic [31:0] wd,
                         output logic e, output int lat, output int nr, output int nw);
        int sz, idx, off, sh;
        bit legal, is_load;
        logic [31:0] word, mask, v;
        idx = int'(a[7:2]);
        off = int'(a[1:0]);
        legal = 1; is_load = 0; sz = 4;
        case (o)
            4'b0000: begin sz = 1; is_load = 1; end
            4'b0001: begin sz = 2; is_load = 1; end
            4'b0011: begin sz = 4; is_load = 1; end
            4'b0100: begin sz = 1; is_load = 1; end
            4'b0101: begin sz = 2; is_load = 1; end
            4'b1000: sz = 1;
            4'b1001: sz = 2;
            4'b1011: sz = 4;
            default: legal = 0;
        endcase
        e = !legal || (off % sz != 0);
        word = ref_mem[idx];
        mask = (sz == 4) ? 32'hFFFF_FFFF : (sz == 2 ? 32'h0000_FFFF : 32'h0000_00FF);
        if (e) begin
            lat = 2; nr = 0; nw = 0;
        end else begin
            sh = (4 - sz - off) * 8;
            if (is_load) begin
                v = (word >> sh) & mask;
                if (!o[2] && v[sz*8-1]) v = v | ~mask;
                exp_rdata = v;
                lat = 3; nr = 1; nw = 0;
            end else begin
                ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
                nw = 1;
                nr = (sz == 4) ? 0 : 1;
                lat = (sz == 4) ? 2 : 4;
            end
        end
    endtask

    // Called at a negedge with the request already on the inputs; returns at
    // the negedge where done is seen. With b2b, req stays high and the next
    // request is presented so it is accepted in the done cycle.
    task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [31:0] wd,
                          input bit b2b, input logic [3:0] no, input logic [7:0] na,
                          input logic [31:0] nwd);
        logic e;
        int lat, nr, nw, k, reads, writes;
        bit both, bad_mid, bad_addr;
        model(o, a, wd, e, lat, nr, nw);
        reads = 0; writes = 0; both = 0; bad_mid = 0; bad_addr = 0;
        @(posedge clk);
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (b2b) begin op = no; addr = na; wdata = nwd; end
                else req = 1'b0;
            end
            if (mem_read && mem_write) both = 1;
            if (mem_read) reads++;
            if (mem_write) writes++;
            if ((mem_read || mem_write) && mem_address != a[7:2]) bad_addr = 1;
            if (done) break;
            if (!busy) bad_mid = 1;
        end
        check($sformatf("latency op=%h a=%h", o, a), 32'(k), 32'(lat));
        check($sformatf("err op=%h a=%h", o, a), 32'(err), 32'(e));
        check($sformatf("rdata op=%h a=%h", o, a), rdata, exp_rdata);
        check($sformatf("reads op=%h a=%h", o, a), 32'(reads), 32'(nr));
        check($sformatf("writes op=%h a=%h", o, a), 32'(writes), 32'(nw));
        check("rd_wr_overlap", 32'(both), 32'd0);
        check("mem_address", 32'(bad_addr), 32'd0);
        check("busy_mid_or_idle_at_done", {bad_mid, busy}, 32'd0);
    endtask

    task automatic single(input logic [3:0] o, input logic [7:0] a, input logic [31:0] wd);
        req = 1'b1; op = o; addr = a; wdata = wd;
        run_op(o, a, wd, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] tbl [8];
        int r;
        tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1011};
        r = int'($urandom_range(0, 9));
        if (r < 8) return tbl[r];
        return 4'($urandom);
    endfunction

    initial begin
        logic [3:0]  co, no;
        logic [7:0]  ca, na;
        logic [31:0] cw, nwd;
        bit          wr_seen;

        rst = 1'b1; req = 1'b0; op = 4'h0; addr = 8'h00; wdata = 32'h0;
        ld_en = 1'b0; ld_addr = 6'h0; ld_data = 32'h0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 64; i++) poke(i, $urandom);
        poke(1, 32'd10);
        poke(2, 32'd20);
        @(negedge clk);
        check("reset rdata", rdata, 32'h0);
        check("reset done/err/busy", {done, err, busy}, 32'h0);
        check("reset mem strobes", {mem_read, mem_write}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        single(4'b0011, 8'h04, 32'h0);
        check("LW word1", rdata, 32'h0000_000A);
        single(4'b1011, 8'h04, 32'h80F0_7F01);
        single(4'b0000, 8'h05, 32'h0);
        check("LB 0x05", rdata, 32'hFFFF_FFF0);
        single(4'b0100, 8'h05, 32'h0);
        single(4'b0001, 8'h04, 32'h0);
        check("LH 0x04", rdata, 32'hFFFF_80F0);
        single(4'b0101, 8'h06, 32'h0);
        single(4'b1000, 8'h0B, 32'h0000_00AA);
        single(4'b1001, 8'h08, 32'h0000_1234);
        single(4'b0011, 8'h08, 32'h0);
        check("LW word2 after SB/SH", rdata, 32'h1234_00AA);
        single(4'b0011, 8'h06, 32'h0);
        single(4'b1001, 8'h09, 32'h0);
        single(4'b0010, 8'h00, 32'h0);
        check("rdata kept after faults", rdata, 32'h1234_00AA);

        // Reset lands while the SB is in DATA: the write must never happen.
        req = 1'b1; op = 4'b1000; addr = 8'h0B; wdata = 32'h55;
        @(posedge clk);
        wr_seen = 0;
        @(negedge clk); req = 1'b0; wr_seen |= mem_write;
        @(negedge clk); rst = 1'b1; wr_seen |= mem_write;
        @(negedge clk); rst = 1'b0; wr_seen |= mem_write;
        exp_rdata = 32'h0;
        check("busy/done after mid reset", {busy, done}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_seen |= mem_write;
            if (done) wr_seen = 1;
        end
        check("no write/done after reset", 32'(wr_seen), 32'd0);
        check("word2 intact", mem[2], ref_mem[2]);

        // req held high: alternating LW/SW, then random mixed traffic.
        co = 4'b0011; ca = 8'h0C; cw = 32'h0;
        req = 1'b1; op = co; addr = ca; wdata = cw;
        for (int i = 0; i < 10; i++) begin
            no = (i % 2 == 0) ? 4'b1011 : 4'b0011;
            na = 8'(($urandom_range(0, 63)) * 4);
            nwd = $urandom;
            run_op(co, ca, cw, 1'b1, no, na, nwd);
            co = no; ca = na; cw = nwd;
        end
        for (int i = 0; i < 300; i++) begin
            no = rand_op();
            na = 8'($urandom);
            nwd = $urandom;
            run_op(co, ca, cw, (i != 299), no, na, nwd);
            co = no; ca = na; cw = nwd;
        end
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        begin
            int diffs = 0;
            for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
            check("final memory image diffs", 32'(diffs), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the single-port word data memory: sits between the datapath and the memory.
- Converts MIPS byte-addressed loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) into word-wide mem_read/mem_write transactions.
- Handles the memory's one-cycle registered read latency, sign/zero extension, alignment checking, and read-modify-write for sub-word stores.
- Big-endian: byte address offset 0 maps to bits 31:24.

Parameters:
ADDR_WIDTH, 6, word-address width of the data memory (64 words); the byte address is ADDR_WIDTH+2 bits.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
req  in  1  request strobe; sampled only in IDLE
op  in  4  MIPS opcode[3:0]: LB 0000, LH 0001, LW 0011, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1011
addr  in  ADDR_WIDTH+2  byte address
wdata  in  32  store data; SB uses [7:0], SH uses [15:0]
rdata  out  32  load result, registered
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with done: misaligned or illegal op
busy  out  1  high whenever state != IDLE
mem_read  out  1  to memory mem_read
mem_write  out  1  to memory mem_write
mem_address  out  ADDR_WIDTH  word address = addr[ADDR_WIDTH+1:2], from latched request
mem_write_data  out  32  to memory write_data
mem_read_data  in  32  from memory read_data; valid the cycle after mem_read

Behaviour:
- States: IDLE, READ, DATA, WRITE, FAULT.
- Reset values: state=IDLE; rdata=0, done=0, err=0, busy=0.
- mem_read and mem_write are forced to 0 combinationally whenever rst=1.
- In IDLE with req=1: latch op, addr and wdata.
  - Check alignment first: LW/SW need addr[1:0]=0; LH/LHU/SH need addr[0]=0.
  - Misaligned or unlisted op -> FAULT. Otherwise, load, SB or SH -> READ; SW -> WRITE.
- req is ignored outside IDLE. A new req is accepted in the same cycle done is high (state is IDLE).
- READ: mem_read=1, mem_write=0. Next state DATA.
- DATA: mem_read_data holds the addressed word.
  - Load: register the extracted, extended value into rdata; pulse done; -> IDLE.
    - LB/LBU select byte addr[1:0] (0 = [31:24] … 3 = [7:0]).
    - LH/LHU select the half by addr[1] (0 = [31:16]).
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH: register the merged word (old word with the target byte/half replaced by wdata[7:0]/[15:0]); -> WRITE.
- WRITE: mem_write=1, mem_read=0. mem_write_data = latched wdata for SW, or the merged word for SB/SH. Pulse done; -> IDLE.
- FAULT: no memory access. Pulse done and err together; -> IDLE. rdata is unchanged.
- Stores and faults never modify rdata.
- Latency, counted from the accept cycle (cycle 0) to the cycle done is visible:
  - loads: 3
  - SW: 2
  - SB/SH: 4
  - fault: 2
- mem_read and mem_write are never both high. Outside READ and WRITE, both are 0.
- Reset mid-operation:
  - Any state returns to IDLE.
  - A pending WRITE is suppressed, so no partial store occurs.
  - No done pulse follows.

Test Plan:
- Memory word1=10. LW addr=0x04 -> mem_read high 1 cycle, mem_address=1; rdata=0x0000000A with done at cycle 3; err=0.
- SW addr=0x04 wdata=0x80F07F01 -> single mem_write cycle, done at cycle 2. Then:
  - LB 0x05 -> 0xFFFFFFF0
  - LBU 0x05 -> 0x000000F0
  - LH 0x04 -> 0xFFFF80F0
  - LHU 0x06 -> 0x00007F01
- Word2=20. SB addr=0x0B wdata=0xAA -> word2=0x000000AA. Then SH addr=0x08 wdata=0x1234 -> LW 0x08 returns 0x123400AA. Check 4-cycle latency and exactly one READ and one WRITE per store.
- LW addr=0x06, SH addr=0x09, op=0010 -> each gives done=err=1 at cycle 2; no mem_read/mem_write; rdata unchanged.
- Assert rst during DATA of SB addr=0x0B -> mem_write never asserts; word2 unchanged; busy=0 and done=0 after reset.
- req held high continuously with alternating LW/SW -> each op accepted only in IDLE; back-to-back done pulses; busy low only in done cycles.
